// File: rtl/banked_reg_file.sv
// AArch64-style integer register file: X0-X30 plus banked SP_EL0/SP_EL1, NRD combinational
// read ports with write bypass, two write ports (W1 wins), and a 33-cycle scrub sequence.
module banked_reg_file #(
  parameter int DATA_W = 64,
  parameter int NRD    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  el_sel,
  input  logic [NRD*5-1:0]      rd_addr,
  input  logic [NRD-1:0]        rd_use_sp,
  output logic [NRD*DATA_W-1:0] rd_data,
  input  logic [1:0]            wr_en,
  input  logic [9:0]            wr_addr,
  input  logic [1:0]            wr_use_sp,
  input  logic [2*DATA_W-1:0]   wr_data,
  input  logic                  clr_start,
  output logic                  busy,
  output logic                  clr_done
);

  typedef enum logic {IDLE, SCRUB} state_t;

  state_t            state, state_nxt;
  logic [5:0]        scrub_idx;
  logic [DATA_W-1:0] regs [0:32];
  logic [5:0]        w_tgt [2];
  logic [1:0]        w_vld;

  // Flat register index: 0-30 = Xn, 31 = SP_EL0, 32 = SP_EL1.
  function automatic logic [5:0] tgt(input logic [4:0] a, input logic el);
    if (a != 5'd31) return {1'b0, a};
    return el ? 6'd32 : 6'd31;
  endfunction

  assign busy = (state == SCRUB);

  for (genvar j = 0; j < 2; j++) begin : g_wr
    assign w_tgt[j] = tgt(wr_addr[5*j +: 5], el_sel);
    assign w_vld[j] = wr_en[j] && !busy && ((wr_addr[5*j +: 5] != 5'd31) || wr_use_sp[j]);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_start) state_nxt = SCRUB;
      SCRUB:   if (scrub_idx == 6'd32) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      scrub_idx <= '0;
      clr_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      // Index only advances while staying in SCRUB, so every new scrub starts at X0.
      scrub_idx <= (state == SCRUB && state_nxt == SCRUB) ? scrub_idx + 6'd1 : 6'd0;
      clr_done  <= (state == SCRUB) && (scrub_idx == 6'd32);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 33; i++) regs[i] <= '0;
    end else if (busy) begin
      regs[scrub_idx] <= '0;
    end else begin
      if (w_vld[0]) regs[w_tgt[0]] <= wr_data[0 +: DATA_W];
      if (w_vld[1]) regs[w_tgt[1]] <= wr_data[DATA_W +: DATA_W];
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [4:0]        a;
    logic [5:0]        t;
    logic              v;
    logic [DATA_W-1:0] d;

    assign a = rd_addr[5*k +: 5];
    assign t = tgt(a, el_sel);
    assign v = (a != 5'd31) || rd_use_sp[k];

    // W1 is checked last so it overrides W0 on a shared target; w_vld already excludes busy.
    always_comb begin
      d = '0;
      if (v) begin
        d = regs[t];
        if (w_vld[0] && w_tgt[0] == t) d = wr_data[0 +: DATA_W];
        if (w_vld[1] && w_tgt[1] == t) d = wr_data[DATA_W +: DATA_W];
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = d;
  end

endmodule

// File: tb/tb_banked_reg_file.sv
// Directed bench for banked_reg_file: vector table for read/write/bypass/SP banking,
// plus hand-written scrub and reset-during-scrub sequences.
module tb_banked_reg_file;
  localparam int DW  = 64;
  localparam int NRD = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              el_sel;
  logic [NRD*5-1:0]  rd_addr;
  logic [NRD-1:0]    rd_use_sp;
  logic [NRD*DW-1:0] rd_data;
  logic [1:0]        wr_en;
  logic [9:0]        wr_addr;
  logic [1:0]        wr_use_sp;
  logic [2*DW-1:0]   wr_data;
  logic              clr_start;
  logic              busy;
  logic              clr_done;

  int checks = 0;
  int errors = 0;

  banked_reg_file #(.DATA_W(DW), .NRD(NRD)) dut (
    .clk(clk), .reset(reset), .el_sel(el_sel),
    .rd_addr(rd_addr), .rd_use_sp(rd_use_sp), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_use_sp(wr_use_sp), .wr_data(wr_data),
    .clr_start(clr_start), .busy(busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        el;
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic        ws0;
    logic [63:0] wd0;
    logic [4:0]  wa1;
    logic        ws1;
    logic [63:0] wd1;
    logic [4:0]  ra0, ra1, ra2;
    logic [2:0]  rsp;
    logic [63:0] e0, e1, e2;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(input logic el, input logic [1:0] we,
                              input logic [4:0] wa0, input logic ws0, input logic [63:0] wd0,
                              input logic [4:0] wa1, input logic ws1, input logic [63:0] wd1,
                              input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] ra2,
                              input logic [2:0] rsp,
                              input logic [63:0] e0, input logic [63:0] e1, input logic [63:0] e2);
    vec_t v;
    v.el = el; v.we = we;
    v.wa0 = wa0; v.ws0 = ws0; v.wd0 = wd0;
    v.wa1 = wa1; v.ws1 = ws1; v.wd1 = wd1;
    v.ra0 = ra0; v.ra1 = ra1; v.ra2 = ra2; v.rsp = rsp;
    v.e0 = e0; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive_wr(input logic [1:0] we,
                          input logic [4:0] wa0, input logic ws0, input logic [63:0] wd0,
                          input logic [4:0] wa1, input logic ws1, input logic [63:0] wd1);
    wr_en     = we;
    wr_addr   = {wa1, wa0};
    wr_use_sp = {ws1, ws0};
    wr_data   = {wd1, wd0};
  endtask

  task automatic set_rd(input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] ra2,
                        input logic [2:0] rsp);
    rd_addr   = {ra2, ra1, ra0};
    rd_use_sp = rsp;
  endtask

  function automatic logic [63:0] rdp(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  initial begin
    int nbusy, ndone, last_busy, done_at;
    bit seen;

    reset = 1'b1; el_sel = 1'b0; clr_start = 1'b0;
    drive_wr(2'b00, 0, 0, 0, 0, 0, 0);
    set_rd(0, 0, 0, 3'b000);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    vecs[0]  = mk(0, 2'b00,  0, 0, 0,               0, 0, 0,     0,  5, 31, 3'b100, 0, 0, 0);
    vecs[1]  = mk(0, 2'b01,  5, 0, 64'hDEAD_BEEF,   0, 0, 0,     5,  6, 31, 3'b000, 64'hDEAD_BEEF, 0, 0);
    vecs[2]  = mk(0, 2'b00,  0, 0, 0,               0, 0, 0,     5,  6, 31, 3'b000, 64'hDEAD_BEEF, 0, 0);
    vecs[3]  = mk(0, 2'b11,  7, 0, 64'h11,          7, 0, 64'h22, 7, 5, 31, 3'b100, 64'h22, 64'hDEAD_BEEF, 0);
    vecs[4]  = mk(0, 2'b00,  0, 0, 0,               0, 0, 0,     7,  5,  0, 3'b000, 64'h22, 64'hDEAD_BEEF, 0);
    vecs[5]  = mk(1, 2'b01, 31, 1, 64'h8000,        0, 0, 0,    31, 31,  7, 3'b001, 64'h8000, 0, 64'h22);
    vecs[6]  = mk(1, 2'b00,  0, 0, 0,               0, 0, 0,    31, 31,  0, 3'b001, 64'h8000, 0, 0);
    vecs[7]  = mk(0, 2'b00,  0, 0, 0,               0, 0, 0,    31, 31,  0, 3'b001, 0, 0, 0);
    vecs[8]  = mk(0, 2'b10,  0, 0, 0,              31, 0, 64'h55, 31, 31, 5, 3'b010, 0, 0, 64'hDEAD_BEEF);
    vecs[9]  = mk(1, 2'b00,  0, 0, 0,               0, 0, 0,    31,  7,  5, 3'b001, 64'h8000, 64'h22, 64'hDEAD_BEEF);
    vecs[10] = mk(0, 2'b11, 31, 1, 64'hA0,         30, 0, 64'h30, 31, 30, 31, 3'b101, 64'hA0, 64'h30, 64'hA0);
    vecs[11] = mk(1, 2'b00,  0, 0, 0,               0, 0, 0,    31, 30, 29, 3'b001, 64'h8000, 64'h30, 0);
    vecs[12] = mk(0, 2'b11,  3, 0, 64'h1,           4, 0, 64'h2,  3,  4, 31, 3'b100, 64'h1, 64'h2, 64'hA0);

    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_clr_done", {63'd0, clr_done}, 64'd0);

    for (int i = 0; i < 13; i++) begin
      el_sel = vecs[i].el;
      drive_wr(vecs[i].we, vecs[i].wa0, vecs[i].ws0, vecs[i].wd0, vecs[i].wa1, vecs[i].ws1, vecs[i].wd1);
      set_rd(vecs[i].ra0, vecs[i].ra1, vecs[i].ra2, vecs[i].rsp);
      #1;
      chk($sformatf("vec%0d_p0", i), rdp(0), vecs[i].e0);
      chk($sformatf("vec%0d_p1", i), rdp(1), vecs[i].e1);
      chk($sformatf("vec%0d_p2", i), rdp(2), vecs[i].e2);
      @(negedge clk);
    end
    drive_wr(2'b00, 0, 0, 0, 0, 0, 0);

    // Preload every register: X_n = 0x1000+n, SP_EL0 = 0x2000, SP_EL1 = 0x2001.
    el_sel = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i < 15) drive_wr(2'b11, 5'(2*i), 0, 64'h1000 + 64'(2*i), 5'(2*i+1), 0, 64'h1000 + 64'(2*i+1));
      else        drive_wr(2'b11, 5'd30, 0, 64'h1000 + 64'd30, 5'd31, 1, 64'h2000);
      @(negedge clk);
    end
    el_sel = 1'b1;
    drive_wr(2'b01, 5'd31, 1, 64'h2001, 0, 0, 0);
    @(negedge clk);
    drive_wr(2'b00, 0, 0, 0, 0, 0, 0);
    el_sel = 1'b0;
    set_rd(10, 31, 0, 3'b010);
    #1;
    chk("preload_x10", rdp(0), 64'h100A);
    chk("preload_sp0", rdp(1), 64'h2000);

    @(negedge clk);
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    nbusy = 0; ndone = 0; last_busy = -1; done_at = -1;
    for (int c = 0; c < 60; c++) begin
      if (busy) begin nbusy++; last_busy = c; end
      if (clr_done) begin ndone++; done_at = c; end
      if (c == 0) begin
        set_rd(20, 0, 0, 3'b000);
        drive_wr(2'b01, 5'd20, 0, 64'hFFFF, 0, 0, 0);
        #1;
        chk("scrub_no_bypass", rdp(0), 64'h1014);
      end else if (busy) begin
        drive_wr(2'b11, 5'd21, 0, 64'hFFFF, 5'd31, 1, 64'hEEEE);
        clr_start = (c >= 5 && c < 10);
      end else begin
        drive_wr(2'b00, 0, 0, 0, 0, 0, 0);
        clr_start = 1'b0;
      end
      @(negedge clk);
    end
    drive_wr(2'b00, 0, 0, 0, 0, 0, 0);
    clr_start = 1'b0;
    chk("scrub_busy_cycles", 64'(nbusy), 64'd33);
    chk("scrub_last_busy", 64'(last_busy), 64'd32);
    chk("scrub_done_pulses", 64'(ndone), 64'd1);
    chk("scrub_done_cycle", 64'(done_at), 64'd33);

    el_sel = 1'b0;
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 0, 0, 3'b001);
      #1;
      chk($sformatf("scrubbed_r%0d", a), rdp(0), 64'd0);
    end
    el_sel = 1'b1;
    set_rd(31, 0, 0, 3'b001);
    #1;
    chk("scrubbed_sp1", rdp(0), 64'd0);

    // Reset in the middle of a scrub.
    @(negedge clk);
    drive_wr(2'b11, 5'd5, 0, 64'h5, 5'd15, 0, 64'h15);
    @(negedge clk);
    el_sel = 1'b1;
    drive_wr(2'b01, 5'd31, 1, 64'h77, 0, 0, 0);
    @(negedge clk);
    drive_wr(2'b00, 0, 0, 0, 0, 0, 0);
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_scrub_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    clr_start = 1'b1;
    drive_wr(2'b01, 5'd5, 0, 64'h99, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    clr_start = 1'b0;
    drive_wr(2'b00, 0, 0, 0, 0, 0, 0);
    set_rd(5, 15, 31, 3'b100);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_clr_done", {63'd0, clr_done}, 64'd0);
    chk("rst_x5", rdp(0), 64'd0);
    chk("rst_x15", rdp(1), 64'd0);
    chk("rst_sp1", rdp(2), 64'd0);

    @(negedge clk);
    drive_wr(2'b11, 5'd0, 0, 64'hAA, 5'd1, 0, 64'hBB);
    @(negedge clk);
    drive_wr(2'b00, 0, 0, 0, 0, 0, 0);
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    set_rd(0, 1, 0, 3'b000);
    #1;
    chk("restart_busy", {63'd0, busy}, 64'd1);
    chk("restart_c0_x0", rdp(0), 64'hAA);
    chk("restart_c0_x1", rdp(1), 64'hBB);
    @(negedge clk);
    chk("restart_c1_x0", rdp(0), 64'd0);
    chk("restart_c1_x1", rdp(1), 64'hBB);

    seen = 1'b0;
    nbusy = 2;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (clr_done) seen = 1'b1;
      else if (busy) nbusy++;
    end
    chk("restart_done_seen", {63'd0, seen}, 64'd1);
    chk("restart_busy_cycles", 64'(nbusy), 64'd33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
